// File: rtl/systolic_array.sv
// Output-stationary NxN unsigned MAC array: skewed X rows and Y columns accumulate C = X*Y over
// WORD terms, then the N*N results drain row-major over valid/ready. Define ACC_SAT_EN to saturate.
module systolic_array #(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int WORD  = 8,
  parameter int ACC_W = 2 * D_W + $clog2(WORD),
  localparam int IDX_W = (N > 1) ? $clog2(N * N) : 1,
  localparam int CNT_W = $clog2(WORD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*D_W-1:0]   in_x,
  input  logic [N-1:0]       in_x_valid,
  input  logic [N*D_W-1:0]   in_y,
  input  logic [N-1:0]       in_y_valid,
  input  logic               clear,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic [IDX_W-1:0]   res_idx,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // PE pipeline and accumulator storage
  logic [D_W-1:0]   r_x   [N][N];
  logic             r_xv  [N][N];
  logic [D_W-1:0]   r_y   [N][N];
  logic             r_yv  [N][N];
  logic [ACC_W-1:0] r_acc [N][N];

  logic [D_W-1:0]   w_xin     [N][N];
  logic             w_xvin    [N][N];
  logic [D_W-1:0]   w_yin     [N][N];
  logic             w_yvin    [N][N];
  logic [ACC_W-1:0] w_acc_nxt [N][N];
  logic [ACC_W-1:0] w_acc_flat [N*N];
  logic [N*N-1:0]   w_mac;
  logic [N*N-1:0]   w_perr;

  logic [CNT_W-1:0] r_cnt;
  logic             r_res_valid;
  logic [IDX_W-1:0] r_res_idx;
  logic             r_done;
  logic             r_err;

  logic [N-1:0]     w_x_valid;
  logic [N-1:0]     w_y_valid;
  logic             w_drain_viol;
  logic             w_last_mac;
  logic             w_accept;
  logic             w_last_accept;

  // Operands arriving while draining are dropped so they cannot disturb finished results.
  assign w_x_valid    = in_x_valid & {N{r_state != S_DRAIN}};
  assign w_y_valid    = in_y_valid & {N{r_state != S_DRAIN}};
  assign w_drain_viol = (r_state == S_DRAIN) && ((|in_x_valid) || (|in_y_valid));

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [2*D_W-1:0] w_prod;

      if (c == 0) begin : g_x_edge
        assign w_xin[r][c]  = in_x[r*D_W +: D_W];
        assign w_xvin[r][c] = w_x_valid[r];
      end else begin : g_x_chain
        assign w_xin[r][c]  = r_x[r][c-1];
        assign w_xvin[r][c] = r_xv[r][c-1];
      end

      if (r == 0) begin : g_y_edge
        assign w_yin[r][c]  = in_y[c*D_W +: D_W];
        assign w_yvin[r][c] = w_y_valid[c];
      end else begin : g_y_chain
        assign w_yin[r][c]  = r_y[r-1][c];
        assign w_yvin[r][c] = r_yv[r-1][c];
      end

      assign w_prod             = w_xin[r][c] * w_yin[r][c];
      assign w_mac[r*N+c]       = w_xvin[r][c] & w_yvin[r][c];
      assign w_perr[r*N+c]      = w_xvin[r][c] ^ w_yvin[r][c];
      assign w_acc_flat[r*N+c]  = r_acc[r][c];

`ifdef ACC_SAT_EN
      logic [ACC_W:0] w_sum;
      assign w_sum            = {1'b0, r_acc[r][c]} + (ACC_W+1)'(w_prod);
      assign w_acc_nxt[r][c]  = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
      assign w_acc_nxt[r][c]  = r_acc[r][c] + ACC_W'(w_prod);
`endif
    end
  end

  // The bottom-right PE sees the final term of the last dot product.
  assign w_last_mac    = (r_state != S_DRAIN) && w_mac[N*N-1] && (r_cnt == CNT_W'(WORD - 1));
  assign w_accept      = r_res_valid && res_ready;
  assign w_last_accept = w_accept && (r_res_idx == IDX_W'(N * N - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_last_mac) begin
          w_state_nxt = S_DRAIN;
        end else if ((|in_x_valid) || (|in_y_valid)) begin
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_last_mac) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_accept) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last_accept;
      r_err   <= r_err | (|w_perr) | w_drain_viol;

      if (w_last_accept) begin
        r_cnt <= '0;
      end else if ((r_state != S_DRAIN) && w_mac[N*N-1]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // First DRAIN cycle only raises valid, so results appear one cycle after the last MAC settles.
      if (r_state == S_DRAIN) begin
        if (!r_res_valid) begin
          r_res_valid <= 1'b1;
        end else if (res_ready) begin
          if (w_last_accept) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
          end else begin
            r_res_idx   <= r_res_idx + IDX_W'(1);
          end
        end
      end
    end
  end

  // NOTE: the PE array is reset explicitly; accumulators must read zero before the first run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_x[r][c]   <= '0;
          r_xv[r][c]  <= 1'b0;
          r_y[r][c]   <= '0;
          r_yv[r][c]  <= 1'b0;
          r_acc[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_x[r][c] <= w_xin[r][c];
          r_y[r][c] <= w_yin[r][c];
          if (clear) begin
            r_xv[r][c]  <= 1'b0;
            r_yv[r][c]  <= 1'b0;
            r_acc[r][c] <= '0;
          end else begin
            r_xv[r][c] <= w_xvin[r][c];
            r_yv[r][c] <= w_yvin[r][c];
            if (w_last_accept) begin
              r_acc[r][c] <= '0;
            end else if (w_mac[r*N+c]) begin
              r_acc[r][c] <= w_acc_nxt[r][c];
            end
          end
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign res_valid = r_res_valid;
  assign res_idx   = r_res_idx;
  assign res_data  = r_res_valid ? w_acc_flat[r_res_idx] : '0;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array (N=2, WORD=2, ACC_W=16): table of matrix products with
// hand-computed results, plus clear, pairing-error, drain-error and async-reset sequences.
module tb_systolic_array;

  localparam int D_W   = 8;
  localparam int N     = 2;
  localparam int WORD  = 2;
  localparam int ACC_W = 16;
  localparam int LAT   = 2 * (N - 1) + WORD + 1;

`ifdef ACC_SAT_EN
  localparam logic [15:0] FULL_C = 16'd65535;
`else
  localparam logic [15:0] FULL_C = 16'd64514;
`endif

  typedef struct packed {
    logic [3:0][7:0]  x;            // X[r][k] at r*2+k
    logic [3:0][7:0]  y;            // Y[k][c] at k*2+c
    logic [3:0][15:0] c;            // C[r][c] at r*2+c
    int               stall_idx;
    int               stall_cycles;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*D_W-1:0]   in_x;
  logic [N-1:0]       in_x_valid;
  logic [N*D_W-1:0]   in_y;
  logic [N-1:0]       in_y_valid;
  logic               clear;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic [ACC_W-1:0]   res_data;
  logic [1:0]         res_idx;
  logic               done;
  logic               err;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  systolic_array #(
    .D_W  (D_W),
    .N    (N),
    .WORD (WORD),
    .ACC_W(ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_x      (in_x),
    .in_x_valid(in_x_valid),
    .in_y      (in_y),
    .in_y_valid(in_y_valid),
    .clear     (clear),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] x00, x01, x10, x11,
                              input logic [7:0] y00, y01, y10, y11,
                              input logic [15:0] c00, c01, c10, c11,
                              input int si, sc);
    vec_t v;
    v.x = {x11, x10, x01, x00};
    v.y = {y11, y10, y01, y00};
    v.c = {c11, c10, c01, c00};
    v.stall_idx    = si;
    v.stall_cycles = sc;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Skewed beat t: row r carries X[r][t-r], column c carries Y[t-c][c].
  task automatic drive_beat(input vec_t v, input int t);
    for (int i = 0; i < N; i++) begin
      automatic int k = t - i;
      if (k >= 0 && k < WORD) begin
        in_x[i*D_W +: D_W] = v.x[i*WORD + k];
        in_y[i*D_W +: D_W] = v.y[k*N + i];
        in_x_valid[i]      = 1'b1;
        in_y_valid[i]      = 1'b1;
      end else begin
        in_x[i*D_W +: D_W] = '0;
        in_y[i*D_W +: D_W] = '0;
        in_x_valid[i]      = 1'b0;
        in_y_valid[i]      = 1'b0;
      end
    end
  endtask

  task automatic compute(input vec_t v, input string nm);
    int lat;
    lat = 0;
    while (lat < 60) begin
      drive_beat(v, lat);
      next_cycle();
      lat++;
      if (lat == 1) check({nm, " busy"}, busy, 1);
      if (res_valid) break;
    end
    drive_beat(v, 1000);
    check({nm, " latency"}, lat, LAT);
  endtask

  task automatic drain(input vec_t v, input string nm, input logic exp_err);
    for (int i = 0; i < N * N; i++) begin
      if (i == v.stall_idx && v.stall_cycles > 0) begin
        res_ready = 1'b0;
        for (int s = 0; s < v.stall_cycles; s++) begin
          check($sformatf("%s hold%0d.%0d", nm, i, s), {res_valid, res_idx, res_data},
                {1'b1, 2'(i), v.c[i]});
          next_cycle();
        end
        res_ready = 1'b1;
      end
      check($sformatf("%s res%0d", nm, i), {res_valid, res_idx, res_data}, {1'b1, 2'(i), v.c[i]});
      next_cycle();
    end
    check({nm, " done"}, {done, res_valid, busy}, 3'b100);
    next_cycle();
    check({nm, " done_pulse"}, done, 0);
    check({nm, " err"}, err, exp_err);
  endtask

  task automatic run_vec(input vec_t v, input string nm, input logic exp_err);
    compute(v, nm);
    drain(v, nm, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1, 2, 3, 4,         5, 6, 7, 8,          19, 22, 43, 50,                 0, 0);
    vecs[1] = mk(1, 2, 3, 4,         5, 6, 7, 8,          19, 22, 43, 50,                 1, 3);
    vecs[2] = mk(255, 255, 255, 255, 255, 255, 255, 255,  FULL_C, FULL_C, FULL_C, FULL_C, 0, 0);
    vecs[3] = mk(0, 0, 0, 0,         9, 9, 9, 9,          0, 0, 0, 0,                     0, 1);
    vecs[4] = mk(2, 0, 0, 3,         10, 20, 30, 40,      20, 40, 90, 120,                3, 2);
    vecs[5] = mk(255, 1, 128, 7,     200, 3, 100, 11,     51100, 776, 26300, 461,         2, 1);

    rst        = 1'b0;
    clear      = 1'b0;
    res_ready  = 1'b1;
    in_x       = '0;
    in_y       = '0;
    in_x_valid = '0;
    in_y_valid = '0;

    #3;
    check("reset busy",      busy,      0);
    check("reset res_valid", res_valid, 0);
    check("reset res_idx",   res_idx,   0);
    check("reset done",      done,      0);
    check("reset err",       err,       0);
    check("reset res_data",  res_data,  0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    check("idle busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Abort after one term; the following run must show no residue.
    drive_beat(vecs[0], 0);
    next_cycle();
    check("clr busy_mid", busy, 1);
    drive_beat(vecs[0], 1000);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    check("clr state", {busy, res_valid, done, err}, 4'b0000);
    run_vec(vecs[0], "clr_run", 1'b0);

    // Lone x valid in IDLE: err sets and sticks, no MAC at PE(0,0).
    in_x[7:0]  = 8'd99;
    in_x_valid = 2'b01;
    next_cycle();
    in_x       = '0;
    in_x_valid = '0;
    check("perr set", err, 1);
    repeat (3) next_cycle();
    check("perr sticky", err, 1);
    run_vec(vecs[0], "perr_run", 1'b1);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    check("perr cleared", {err, busy}, 2'b00);

    // Valid during DRAIN is ignored but flagged, then async reset lands at idx2.
    compute(vecs[0], "rst_run");
    res_ready  = 1'b0;
    in_x_valid = 2'b10;
    next_cycle();
    in_x_valid = '0;
    check("drain_viol err", err, 1);
    check("drain_viol res0", {res_valid, res_idx, res_data}, {1'b1, 2'd0, 16'd19});
    res_ready = 1'b1;
    next_cycle();
    next_cycle();
    res_ready = 1'b0;
    check("rst_run res2", {res_valid, res_idx, res_data}, {1'b1, 2'd2, 16'd43});
    #3;
    rst = 1'b0;
    #1;
    check("async rst outs", {res_valid, busy, done, err}, 4'b0000);
    check("async rst idx", res_idx, 0);
    @(negedge clk);
    rst       = 1'b1;
    res_ready = 1'b1;
    next_cycle();
    run_vec(vecs[0], "post_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
